// File: rtl/fifo_fft_framer.sv
// Frames a stream of FIFO samples into fixed-length FFT input frames.
// Samples are converted from offset-binary to signed two's complement, shifted,
// and presented as {imag=0, real} with a valid/ready handshake and m_last marking.
module fifo_fft_framer #(
  parameter int DATA_WIDTH     = 8,
  parameter int FRAME_LEN_LOG2 = 10,
  parameter int OUT_WIDTH      = 16,
  parameter int SHIFT          = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [2*OUT_WIDTH-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underrun
);

  localparam int CW = FRAME_LEN_LOG2 + 1;
  localparam logic [CW-1:0] FRAME_LEN = {1'b1, {FRAME_LEN_LOG2{1'b0}}};
  localparam logic [CW-1:0] LAST_IDX  = FRAME_LEN - {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         rdCount_q;
  logic [CW-1:0]         txCount_q;
  logic                  inFlight_q;
  logic [DATA_WIDTH-1:0] sampleBuf_q [2];
  logic                  wrPtr_q;
  logic                  rdPtr_q;
  logic [1:0]            occ_q;
  logic                  frameDone_q;
  logic                  underrun_q;

  logic                  pop;
  logic                  lastXfer;
  logic                  startAccept;
  logic                  underrunSet;
  logic                  pushBuf;
  logic                  popBuf;
  logic [1:0]            pending;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] offsetSample;
  logic [OUT_WIDTH-1:0]  realExt;
  logic [OUT_WIDTH-1:0]  realShift;

  // Handshake, read throttling and next-state decode; the head sample bypasses
  // the buffer when it is empty so the first sample appears as soon as it returns.
  always_comb begin
    state_d      = state_q;
    head         = sampleBuf_q[rdPtr_q];
    m_valid      = (occ_q != 2'd0) || inFlight_q;
    pop          = 1'b0;
    m_last       = 1'b0;
    lastXfer     = 1'b0;
    pending      = 2'd0;
    fifo_rd_en   = 1'b0;
    startAccept  = 1'b0;
    underrunSet  = 1'b0;
    pushBuf      = 1'b0;
    popBuf       = 1'b0;

    if (occ_q == 2'd0) begin
      head = fifo_rd_data;
    end

    pop      = m_valid && m_ready;
    m_last   = m_valid && (txCount_q == LAST_IDX);
    lastXfer = pop && m_last;
    pending  = occ_q + {1'b0, inFlight_q} - {1'b0, pop};
    pushBuf  = inFlight_q && !((occ_q == 2'd0) && pop);
    popBuf   = pop && (occ_q != 2'd0);

    fifo_rd_en = (state_q == STREAM) && !fifo_empty &&
                 (rdCount_q < FRAME_LEN) && (pending < 2'd2);

    underrunSet = (state_q == STREAM) && (occ_q == 2'd0) && !inFlight_q &&
                  fifo_empty && (rdCount_q < FRAME_LEN);

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          startAccept = 1'b1;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (lastXfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Offset-binary to two's complement, sign-extend, scale; imag is always zero.
  always_comb begin
    offsetSample = {~head[DATA_WIDTH-1], head[DATA_WIDTH-2:0]};
    realExt      = {{(OUT_WIDTH-DATA_WIDTH){offsetSample[DATA_WIDTH-1]}}, offsetSample};
    realShift    = realExt << SHIFT;
    m_data       = '0;
    if (m_valid) begin
      m_data[OUT_WIDTH-1:0] = realShift;
    end
  end

  // State, frame counters, status flags and the two-entry sample buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rdCount_q      <= '0;
      txCount_q      <= '0;
      inFlight_q     <= 1'b0;
      sampleBuf_q[0] <= '0;
      sampleBuf_q[1] <= '0;
      wrPtr_q        <= 1'b0;
      rdPtr_q        <= 1'b0;
      occ_q          <= 2'd0;
      frameDone_q    <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frameDone_q <= lastXfer;
      inFlight_q  <= fifo_rd_en;

      if (startAccept) begin
        rdCount_q  <= '0;
        txCount_q  <= '0;
        underrun_q <= 1'b0;
      end else begin
        if (fifo_rd_en) begin
          rdCount_q <= rdCount_q + {{(CW-1){1'b0}}, 1'b1};
        end
        if (pop) begin
          txCount_q <= txCount_q + {{(CW-1){1'b0}}, 1'b1};
        end
        if (underrunSet) begin
          underrun_q <= 1'b1;
        end
      end

      if (pushBuf) begin
        sampleBuf_q[wrPtr_q] <= fifo_rd_data;
        wrPtr_q              <= ~wrPtr_q;
      end
      if (popBuf) begin
        rdPtr_q <= ~rdPtr_q;
      end
      occ_q <= occ_q + {1'b0, pushBuf} - {1'b0, popBuf};
    end
  end

  assign busy       = (state_q == STREAM);
  assign frame_done = frameDone_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_fifo_fft_framer.sv
// Directed bench for fifo_fft_framer: a behavioural FIFO feeds the DUT and a
// negedge monitor records transferred beats plus handshake-rule violations.
module tb_fifo_fft_framer;

  localparam int DW   = 8;
  localparam int FL2  = 10;
  localparam int OW   = 16;
  localparam int SH   = 4;
  localparam int FLEN = 1024;
  localparam int MEMD = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [DW-1:0] fifo_rd_data = 8'h00;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [2*OW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;
  logic          frame_done;
  logic          underrun;

  int checks = 0;
  int failures = 0;

  fifo_fft_framer #(
    .DATA_WIDTH(DW),
    .FRAME_LEN_LOG2(FL2),
    .OUT_WIDTH(OW),
    .SHIFT(SH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .busy(busy),
    .frame_done(frame_done),
    .underrun(underrun)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  logic [7:0] fifoMem [0:MEMD-1];
  int wp = 0;
  int rp = 0;
  int flushGen = 0;
  int flushSeen = 0;

  assign fifo_empty = (rp == wp);

  // Behavioural FIFO: one-cycle read latency, flush request drops all contents.
  always @(posedge clk) begin
    if (flushGen != flushSeen) begin
      flushSeen <= flushGen;
      rp <= wp;
    end else if (fifo_rd_en && (rp != wp)) begin
      fifo_rd_data <= fifoMem[rp % MEMD];
      rp <= rp + 1;
    end
  end

  logic [31:0] beats [$];
  int lastPos [$];
  int acceptCount = 0;
  int holdErr = 0;
  int ovErr = 0;
  int doneCount = 0;
  int badDone = 0;
  int clearGen = 0;
  int clearSeen = 0;
  logic prevStall = 1'b0;
  logic prevLastXfer = 1'b0;
  logic prevLastBit = 1'b0;
  logic [31:0] prevData = '0;

  // Monitor: records transfers and counts stall-hold, overfill and frame_done errors.
  always @(negedge clk) begin
    if (clearGen != clearSeen) begin
      clearSeen = clearGen;
      beats.delete();
      lastPos.delete();
      acceptCount = 0;
      holdErr = 0;
      ovErr = 0;
      doneCount = 0;
      badDone = 0;
      prevStall = 1'b0;
      prevLastXfer = 1'b0;
    end
    if (prevStall && (!m_valid || m_data !== prevData || m_last !== prevLastBit)) holdErr++;
    if (fifo_rd_en && ((acceptCount - beats.size() - ((m_valid && m_ready) ? 1 : 0)) >= 2)) ovErr++;
    if (frame_done) begin
      doneCount++;
      if (!prevLastXfer) badDone++;
    end
    if (fifo_rd_en && !fifo_empty) acceptCount++;
    if (m_valid && m_ready) begin
      if (m_last) lastPos.push_back(beats.size());
      beats.push_back(m_data);
    end
    prevStall    = m_valid && !m_ready;
    prevData     = m_data;
    prevLastBit  = m_last;
    prevLastXfer = m_valid && m_ready && m_last;
  end

  function automatic logic [31:0] expWord(input int v);
    int r;
    r = (v - 128) * 16;
    return {16'h0000, r[15:0]};
  endfunction

  function automatic int countBadBeats();
    int bad = 0;
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i] !== expWord((i + 1) % 256)) bad++;
    end
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int startIdx, input int n);
    for (int i = 0; i < n; i++) begin
      fifoMem[wp % MEMD] = 8'((startIdx + i + 1) % 256);
      wp++;
    end
  endtask

  task automatic startFrame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        cycles = n;
        break;
      end
    end
    tick();
  endtask

  task automatic waitBeats(input int target, input int limit, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (beats.size() >= target) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_last got=%b exp=0", m_last); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_m_data got=%h exp=0", m_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun got=%b exp=0", underrun); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    bit seen;
    clearGen++;
    preload(0, FLEN);
    m_ready = 1'b1;
    tick();
    frame_start = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_c0_valid got=%b exp=0", m_valid); end
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_c1_busy got=%b exp=1", busy); end
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("[TB] FAIL basic_c1_rd_en got=%b exp=1", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_c1_valid got=%b exp=0", m_valid); end
    tick();
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_c2_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 32'h0000F810) begin failures++; $display("[TB] FAIL basic_first_data got=%h exp=0000f810", m_data); end
    waitDone(3000, cyc, seen);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (cyc !== 1024) begin failures++; $display("[TB] FAIL basic_done_cycle got=%0d exp=1024", cyc); end
    checks++; if (beats.size() !== FLEN) begin failures++; $display("[TB] FAIL basic_beats got=%0d exp=%0d", beats.size(), FLEN); end
    checks++; if (countBadBeats() !== 0) begin failures++; $display("[TB] FAIL basic_data got_bad=%0d exp_bad=0", countBadBeats()); end
    checks++; if (lastPos.size() !== 1 || lastPos[0] !== FLEN - 1) begin failures++; $display("[TB] FAIL basic_last got_n=%0d exp=1 at 1023", lastPos.size()); end
    checks++; if (doneCount !== 1 || badDone !== 0) begin failures++; $display("[TB] FAIL basic_done got=%0d/%0d exp=1/0", doneCount, badDone); end
    checks++; if (acceptCount !== FLEN) begin failures++; $display("[TB] FAIL basic_reads got=%0d exp=%0d", acceptCount, FLEN); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle got=%b%b exp=00", busy, frame_done); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL basic_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_backpressure();
    logic [15:0] lfsr;
    bit seen;
    lfsr = 16'hACE1;
    seen = 1'b0;
    clearGen++;
    preload(0, FLEN);
    tick();
    startFrame();
    for (int n = 0; n < 6000; n++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      m_ready = lfsr[0];
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    checks++; if (!seen) begin failures++; $display("[TB] FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (beats.size() !== FLEN) begin failures++; $display("[TB] FAIL bp_beats got=%0d exp=%0d", beats.size(), FLEN); end
    checks++; if (countBadBeats() !== 0) begin failures++; $display("[TB] FAIL bp_data got_bad=%0d exp_bad=0", countBadBeats()); end
    checks++; if (holdErr !== 0) begin failures++; $display("[TB] FAIL bp_hold got=%0d exp=0", holdErr); end
    checks++; if (ovErr !== 0) begin failures++; $display("[TB] FAIL bp_overfill got=%0d exp=0", ovErr); end
    checks++; if (lastPos.size() !== 1 || lastPos[0] !== FLEN - 1) begin failures++; $display("[TB] FAIL bp_last got_n=%0d exp=1 at 1023", lastPos.size()); end
    checks++; if (doneCount !== 1 || badDone !== 0) begin failures++; $display("[TB] FAIL bp_done got=%0d/%0d exp=1/0", doneCount, badDone); end
  endtask

  task automatic test_underrun();
    int cyc;
    int gapValid;
    bit seen;
    gapValid = 0;
    clearGen++;
    preload(0, 500);
    m_ready = 1'b1;
    tick();
    startFrame();
    waitBeats(500, 800, seen);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL ur_first_part got=%0d exp=500", beats.size()); end
    repeat (3) tick();
    @(negedge clk);
    checks++; if (underrun !== 1'b1) begin failures++; $display("[TB] FAIL ur_flag got=%b exp=1", underrun); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ur_busy got=%b exp=1", busy); end
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m_valid) gapValid++;
    end
    checks++; if (gapValid !== 0) begin failures++; $display("[TB] FAIL ur_gap_valid got=%0d exp=0", gapValid); end
    checks++; if (beats.size() !== 500) begin failures++; $display("[TB] FAIL ur_gap_beats got=%0d exp=500", beats.size()); end
    tick();
    preload(500, FLEN - 500);
    waitDone(3000, cyc, seen);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL ur_timeout got=no_done exp=done"); end
    checks++; if (beats.size() !== FLEN) begin failures++; $display("[TB] FAIL ur_beats got=%0d exp=%0d", beats.size(), FLEN); end
    checks++; if (countBadBeats() !== 0) begin failures++; $display("[TB] FAIL ur_data got_bad=%0d exp_bad=0", countBadBeats()); end
    checks++; if (lastPos.size() !== 1 || lastPos[0] !== FLEN - 1) begin failures++; $display("[TB] FAIL ur_last got_n=%0d exp=1 at 1023", lastPos.size()); end
    repeat (3) tick();
    checks++; if (underrun !== 1'b1) begin failures++; $display("[TB] FAIL ur_sticky got=%b exp=1", underrun); end
  endtask

  task automatic test_ignore_start();
    int cyc;
    bit seen;
    clearGen++;
    preload(0, FLEN);
    m_ready = 1'b1;
    tick();
    startFrame();
    @(negedge clk);
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL ign_underrun_clear got=%b exp=0", underrun); end
    waitBeats(300, 800, seen);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL ign_reach300 got=%0d exp=300", beats.size()); end
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    waitDone(3000, cyc, seen);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL ign_timeout got=no_done exp=done"); end
    repeat (5) tick();
    checks++; if (beats.size() !== FLEN) begin failures++; $display("[TB] FAIL ign_beats got=%0d exp=%0d", beats.size(), FLEN); end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL ign_done got=%0d exp=1", doneCount); end
    checks++; if (countBadBeats() !== 0) begin failures++; $display("[TB] FAIL ign_data got_bad=%0d exp_bad=0", countBadBeats()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ign_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    clearGen++;
    preload(0, FLEN);
    m_ready = 1'b1;
    tick();
    startFrame();
    waitBeats(600, 1000, seen);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL rm_reach600 got=%0d exp=600", beats.size()); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin failures++; $display("[TB] FAIL rm_ctrl got=%b%b%b exp=000", fifo_rd_en, m_valid, m_last); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("[TB] FAIL rm_data got=%h exp=0", m_data); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || underrun !== 1'b0) begin failures++; $display("[TB] FAIL rm_status got=%b%b%b exp=000", busy, frame_done, underrun); end
    flushGen++;
    repeat (2) tick();
    clearGen++;
    preload(0, FLEN);
    tick();
    startFrame();
    waitDone(3000, cyc, seen);
    checks++; if (!seen) begin failures++; $display("[TB] FAIL rm_timeout got=no_done exp=done"); end
    checks++; if (beats.size() !== FLEN) begin failures++; $display("[TB] FAIL rm_beats got=%0d exp=%0d", beats.size(), FLEN); end
    checks++; if (countBadBeats() !== 0) begin failures++; $display("[TB] FAIL rm_data_order got_bad=%0d exp_bad=0", countBadBeats()); end
    checks++; if (lastPos.size() !== 1 || lastPos[0] !== FLEN - 1) begin failures++; $display("[TB] FAIL rm_last got_n=%0d exp=1 at 1023", lastPos.size()); end
  endtask

  task automatic test_values();
    int cyc;
    bit seen;
    clearGen++;
    fifoMem[wp % MEMD] = 8'h00; wp++;
    fifoMem[wp % MEMD] = 8'h80; wp++;
    fifoMem[wp % MEMD] = 8'hFF; wp++;
    preload(3, FLEN - 3);
    m_ready = 1'b1;
    tick();
    startFrame();
    waitDone(3000, cyc, seen);
    checks++; if (!seen || beats.size() < 3) begin failures++; $display("[TB] FAIL val_timeout got=%0d beats exp=%0d", beats.size(), FLEN); end
    else begin
      checks++; if (beats[0] !== 32'h0000F800) begin failures++; $display("[TB] FAIL val_00 got=%h exp=0000f800", beats[0]); end
      checks++; if (beats[1] !== 32'h00000000) begin failures++; $display("[TB] FAIL val_80 got=%h exp=00000000", beats[1]); end
      checks++; if (beats[2] !== 32'h000007F0) begin failures++; $display("[TB] FAIL val_ff got=%h exp=000007f0", beats[2]); end
    end
  endtask

  // Test sequence.
  initial begin
    $display("[TB] starting fifo_fft_framer bench");
    test_reset();
    test_basic();
    test_backpressure();
    test_underrun();
    test_ignore_start();
    test_reset_mid();
    test_values();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
